// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 scheduled multiplexer and related arbiters.
package mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    // Advance a channel index by one, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_nto1_sched_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping around.
module rr_pick #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    // Scan from the farthest offset down so the closest request to ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int  idx;
            logic hit;
            idx     = (int'(ptr) + i) % N;
            hit     = req[idx];
            gnt_vld = gnt_vld | hit;
            gnt_idx = hit ? SEL_W'(idx) : gnt_idx;
        end
    end

endmodule

// File: rtl/mux_nto1_sched.sv
// N-channel registered multiplexer with valid/ready handshake, direct or round-robin select.
module mux_nto1_sched
    import mux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    mode_e              mode_s;
    logic               load_en_s;
    logic               rr_vld_s;
    logic [SEL_W-1:0]   rr_idx_s;
    logic               gnt_vld_s;
    logic [SEL_W-1:0]   gnt_idx_s;
    logic [N_CH-1:0]    in_ready_s;
    logic               xfer_s;
    logic [WIDTH-1:0]   gnt_data_s;

    logic               out_valid_d, out_valid_q;
    logic [WIDTH-1:0]   out_data_d,  out_data_q;
    logic [SEL_W-1:0]   out_ch_d,    out_ch_q;
    logic [SEL_W-1:0]   ptr_d,       ptr_q;

    rr_pick #(.N(N_CH)) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld_s),
        .gnt_idx (rr_idx_s)
    );

    // Grant selection; an out-of-range direct select yields no grant.
    always_comb begin
        mode_s    = mode_e'(mode);
        load_en_s = !out_valid_q || out_ready;
        if (mode_s == MODE_RR) begin
            gnt_vld_s = rr_vld_s;
            gnt_idx_s = rr_idx_s;
        end else begin
            gnt_vld_s = (int'(sel) < N_CH);
            gnt_idx_s = sel;
        end
    end

    // Ready is one-hot on the granted channel, suppressed by backpressure and reset.
    always_comb begin
        in_ready_s = '0;
        if (rst_n && gnt_vld_s && load_en_s) begin
            in_ready_s[gnt_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
        xfer_s = |(in_ready_s & in_valid);
    end

    // Data of the granted channel.
    always_comb begin
        gnt_data_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            gnt_data_s = (int'(gnt_idx_s) == k) ? in_data[k*WIDTH +: WIDTH] : gnt_data_s;
        end
    end

    // Next state of the output word and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en_s) begin
            out_valid_d = xfer_s;
            if (xfer_s) begin
                out_data_d = gnt_data_s;
                out_ch_d   = gnt_idx_s;
                if (mode_s == MODE_RR) begin
                    ptr_d = SEL_W'(wrap_inc(32'(gnt_idx_s), 32'(N_CH)));
                end else begin
                    ptr_d = ptr_q;
                end
            end else begin
                out_data_d = out_data_q;
                out_ch_d   = out_ch_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nto1_sched.sv
// Randomized and directed bench for mux_nto1_sched against a transaction-level reference model.
module tb_mux_nto1_sched;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int n_checks = 0;
    int n_fail   = 0;

    bit       m_valid;
    bit [3:0] m_data;
    int       m_ch;
    int       m_ptr;

    mux_nto1_sched #(.WIDTH(4), .N_CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nto1_sched #(.WIDTH(4), .N_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the spec's rules grant right now, or -1 for none.
    function automatic int exp_grant();
        if (mode == 1'b0) begin
            return (int'(sel) < 4) ? int'(sel) : -1;
        end
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check ready, advance model at the edge, check registered outputs.
    task automatic tick();
        int       g;
        bit       le;
        bit [3:0] exp_rdy;
        #1;
        g       = exp_grant();
        le      = !m_valid || out_ready;
        exp_rdy = 4'd0;
        if (rst_n && g >= 0 && le) exp_rdy[g] = 1'b1;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_data = 4'd0; m_ch = 0; m_ptr = 0;
        end else if (le) begin
            if (g >= 0 && in_valid[g]) begin
                m_valid = 1'b1;
                m_data  = in_data[g*4 +: 4];
                m_ch    = g;
                if (mode) m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data",  32'(out_data),  32'(m_data));
        check_eq("out_ch",    32'(out_ch),    32'(m_ch));
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] held;
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'd0; in_data = 16'd0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'd0; in_data3 = 12'd0; out_ready3 = 1'b1;
        m_valid = 1'b0; m_data = 4'd0; m_ch = 0; m_ptr = 0;
        @(negedge clk);
        tick(); tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Direct sweep, forward then reversed data.
        in_valid = 4'hF; in_data = {4'd8, 4'd4, 4'd2, 4'd1};
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); tick();
            check_eq("dir_fwd", 32'(out_data), 32'd1 << s);
            check_eq("dir_ch", 32'(out_ch), 32'(s));
        end
        in_data = {4'd1, 4'd2, 4'd4, 4'd8};
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); tick();
            check_eq("dir_rev", 32'(out_data), 32'd8 >> s);
        end
        held = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold", 32'(out_data), 32'(held));
        end

        // Round robin, all valid.
        out_ready = 1'b1; mode = 1'b1; in_data = {4'd8, 4'd4, 4'd2, 4'd1};
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("rr_ch", 32'(out_ch), 32'(i % 4));
            check_eq("rr_data", 32'(out_data), 32'd1 << (i % 4));
        end

        // Round robin with sparse valids from reset.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rr_sparse", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Reset while a word is held and the pointer sits at 2.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        in_valid = 4'hF;
        tick(); tick();
        out_ready = 1'b0; tick();
        rst_n = 1'b0; tick();
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_data", 32'(out_data), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1; tick();
        check_eq("rst_ptr", 32'(out_ch), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            tick();
        end

        // Three-channel instance: out-of-range select.
        rst_n = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'd0; out_ready = 1'b1;
        in_valid3 = 3'b111; in_data3 = {4'd4, 4'd2, 4'd1}; out_ready3 = 1'b0; sel3 = 2'd0;
        tick();
        check_eq("n3_load_valid", 32'(out_valid3), 32'd1);
        check_eq("n3_load_data", 32'(out_data3), 32'd1);
        sel3 = 2'd3;
        #1 check_eq("n3_rdy_bp", 32'(in_ready3), 32'd0);
        tick();
        check_eq("n3_hold_valid", 32'(out_valid3), 32'd1);
        out_ready3 = 1'b1;
        #1 check_eq("n3_rdy_oor", 32'(in_ready3), 32'd0);
        tick();
        check_eq("n3_drop_valid", 32'(out_valid3), 32'd0);
        check_eq("n3_keep_data", 32'(out_data3), 32'd1);
        check_eq("n3_keep_ch", 32'(out_ch3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nto1_sched.md
# mux_nto1_sched

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It is the successor to the fixed 4:1 combinational mux: width and channel count are generic, the output is registered, and a round-robin mode is added alongside direct select. It sits between multiple producer channels and a single downstream consumer wherever a fixed 4:1 case mux was used before.

## Interface
- `WIDTH`, 4: data width per channel.
- `N_CH`, 4: number of input channels, ≥2; need not be a power of two.
- `SEL_W`, `$clog2(N_CH)`: select/channel-index width (derived, not overridden).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  1  0 = DIRECT (channel from `sel`), 1 = ROUND_ROBIN.
- `sel`  in  SEL_W  channel index used in DIRECT mode.
- `in_data`  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  N_CH  per-channel valid.
- `in_ready`  out  N_CH  per-channel ready; at most one bit set (one-hot or zero).
- `out_data`  out  WIDTH  registered output data.
- `out_ch`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.

## Operation
- `load_en = !out_valid || out_ready`. The output register accepts a new word only when `load_en` is high.
- Grant selection, combinational:
  - DIRECT: `g = sel` if `sel < N_CH`, else no grant.
  - ROUND_ROBIN: `g` = first channel with `in_valid` set, scanning `ptr, ptr+1, … N_CH-1, 0, … ptr-1`. No grant if no channel is valid.
- `in_ready[g] = load_en` when a grant exists; all other bits are 0. In DIRECT mode the ready is asserted on channel `sel` regardless of its `in_valid`.
- Input transfer happens when `in_valid[g] && in_ready[g]`. On transfer: `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
- If `load_en` is high and no input transfer occurs, `out_valid <= 0`. `out_data` and `out_ch` hold their values.
- Round-robin pointer:
  - On each transfer in ROUND_ROBIN mode, `ptr <= (g == N_CH-1) ? 0 : g+1`.
  - The pointer does not change in DIRECT mode.
  - It is not reset on a mode change.
- Out-of-range `sel` (possible when N_CH is not a power of two): no grant, `in_ready` all 0, no error flag.
- A change of `mode` or `sel` takes effect in the same cycle. A word already in the output register is unaffected.

## Timing
- Latency: input transfer at edge t → `out_valid`/`out_data` visible after edge t.
- Throughput: 1 word/cycle while `out_ready` stays high. Simultaneous consume and load in the same cycle is required.
- Backpressure: while `out_valid && !out_ready`, `in_ready` is all 0 and `out_data`/`out_ch` are stable.
- Reset (`rst_n` low at a rising edge): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`.
  - `in_ready` is forced to 0 combinationally while `rst_n` is low.
  - A word held mid-transfer is discarded.
- Combinational paths: `in_valid`/`sel`/`mode`/`out_ready` → `in_ready`. No combinational path from inputs to `out_*`.

## Structure
- Shared package `mux_pkg`: `mode_e` enum (`MODE_DIRECT=1'b0`, `MODE_RR=1'b1`).
- Sub-module `rr_pick`:
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt_vld`, `gnt_idx`.
  - Purely combinational rotate-priority encoder; reused by future arbiters.
- Top level contains the output register, the pointer register and the DIRECT/RR grant mux.

## Test plan
- DIRECT, `N_CH=4`, `WIDTH=4`, a/b/c/d = 1/2/4/8, all valid, `out_ready=1`, `sel` stepped 0→3 → `out_data` = 1, 2, 4, 8 one cycle after each change; `out_ch` equals `sel`.
- Reverse data (a/b/c/d = 8/4/2/1), repeat the `sel` sweep → `out_data` = 8, 4, 2, 1. Then hold `out_ready=0` for 5 cycles → `out_data` stable, `in_ready` all 0.
- ROUND_ROBIN, all valid, `out_ready=1` → `out_ch` sequence 0,1,2,3,0,1… and `out_data` 1,2,4,8,1… at one word/cycle.
- ROUND_ROBIN, `in_valid=4'b1010`, from reset → `out_ch` 1,3,1,3; channels 0 and 2 never see `in_ready`.
- `N_CH=3`, DIRECT with `sel=3` → `in_ready=0`, `out_valid` drops after the pending word is consumed.
- Assert `rst_n=0` for 1 cycle while `out_valid=1` and `ptr=2` → next cycle `out_valid=0`, `out_data=0`. The next RR grant with all channels valid is channel 0.
